main_memory: RTL

Block-granular main-memory responder for the memory side of `L2_cache`. It accepts block read and block write requests on the `mem_*` interface, waits a configurable latency, and completes each request with a one-cycle `mem_ready` pulse. It is the behavioural and synthesizable backing store behind the L2 in system benches. It is sized by the same `DATA_WIDTH`, `ADDR_WIDTH` and `BLOCK_SIZE` parameters as the cache.

---
 rtl/main_memory.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/main_memory.sv
// main_memory -- block-granular backing store behind the L2 cache.
//
// Accepts one block read or block write on the mem_* interface, waits the
// configured latency, performs the operation and signals completion with a
// single-cycle mem_ready pulse. When mem_read and mem_write are both high at
// acceptance, the write is served and the read is dropped.
//
// Optional build macro: MAIN_MEM_STATS_EN adds 16-bit saturating completion
// counters rd_count / wr_count. With the macro undefined the ports and
// counters are absent.
//
// Ports
//   clk            : single clock, rising edge
//   rst_n          : asynchronous active-low reset (control and read register;
//                    the storage array is never reset)
//   mem_addr       : word address; block index = mem_addr[ADDR_WIDTH-1:OFS]
//   mem_data_out   : write block from the L2
//   mem_read       : read request, held until mem_ready
//   mem_write      : write request, held until mem_ready
//   mem_data_block : registered read data, updates only on read completion
//   mem_ready      : one-cycle completion pulse
//   rd_count       : (MAIN_MEM_STATS_EN) completed reads, saturating
//   wr_count       : (MAIN_MEM_STATS_EN) completed writes, saturating
//
// Power-up contents are word w of block b = b*BLOCK_SIZE + w. The array
// stores the XOR difference from that pattern, so a RAM that comes up cleared
// reads back the required power-up image without any load logic.
module main_memory #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 11,
   parameter int BLOCK_SIZE    = 32,
   parameter int READ_LATENCY  = 4,
   parameter int WRITE_LATENCY = 4
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [ADDR_WIDTH-1:0]                mem_addr,
   input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_out,
   input  logic                                 mem_read,
   input  logic                                 mem_write,
   output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_block,
   output logic                                 mem_ready
`ifdef MAIN_MEM_STATS_EN
   ,
   output logic [15:0]                          rd_count,
   output logic [15:0]                          wr_count
`endif
);

   localparam int OFS     = $clog2(BLOCK_SIZE);
   localparam int IDX_W   = ADDR_WIDTH - OFS;
   localparam int DEPTH   = 2 ** IDX_W;
   localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
   localparam int CNT_W   = $clog2(MAX_LAT) + 1;

   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
   localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

   typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] block_t;
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             accept;
   logic             complete;

   logic [IDX_W-1:0] idx_p0;
   logic             wr_op_p0;
   block_t           wdata_p0;

   block_t           delta [DEPTH];

   // Offset bits select a word inside the block and play no part here.
   logic unused_ofs;
   assign unused_ofs = ^mem_addr[OFS-1:0];

   // Power-up image of one block: the word address itself, zero-extended.
   function automatic block_t init_block(input logic [IDX_W-1:0] b);
      block_t blk;
      for (int w = 0; w < BLOCK_SIZE; w++) begin
         blk[w] = DATA_WIDTH'({b, OFS'(w)});
      end
      return blk;
   endfunction

`ifdef MAIN_MEM_STATS_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction
`endif

   // Control FSM: next state, counter and outputs.
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      accept    = 1'b0;
      complete  = 1'b0;
      mem_ready = 1'b0;
      case (state)
         IDLE: begin
            if (mem_write || mem_read) begin
               accept   = 1'b1;
               cnt_nx   = mem_write ? WR_LOAD : RD_LOAD;
               state_nx = BUSY;
            end
         end
         BUSY: begin
            if (cnt == '0) begin
               complete = 1'b1;
               state_nx = RESP;
            end else begin
               cnt_nx = cnt - CNT_W'(1);
            end
         end
         RESP: begin
            mem_ready = 1'b1;
            state_nx  = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Stage p0: request captured at acceptance; later input changes ignored.
   // A simultaneous read is dropped because mem_write selects the write op.
   always_ff @(posedge clk) begin
      if (accept) begin
         idx_p0   <= mem_addr[ADDR_WIDTH-1:OFS];
         wr_op_p0 <= mem_write;
         wdata_p0 <= mem_data_out;
      end
   end

   // Completion: storage update and registered read data.
   always_ff @(posedge clk) begin
      if (complete && wr_op_p0) begin
         delta[idx_p0] <= wdata_p0 ^ init_block(idx_p0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_data_block <= '0;
      end else if (complete && !wr_op_p0) begin
         mem_data_block <= delta[idx_p0] ^ init_block(idx_p0);
      end
   end

`ifdef MAIN_MEM_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_count <= '0;
         wr_count <= '0;
      end else if (complete) begin
         if (wr_op_p0) wr_count <= sat_inc(wr_count);
         else          rd_count <= sat_inc(rd_count);
      end
   end
`endif

endmodule
